// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock / reset sequencer.
// State encoding, NTSC divider defaults and a counter-width helper.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_STABLE,
    S_HOLD,
    S_RUN
  } pll_state_t;

  localparam int TIA_DIV_NTSC = 8;
  localparam int CPU_DIV_NTSC = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_ce_divider.sv
// Colour-clock and CPU clock-enable divider (ce_divider).
// clr wins over run; enables are registered single-cycle pulses.
module ce_divider
  import pll_seq_pkg::*;
#(
  parameter int TIA_DIV = TIA_DIV_NTSC,
  parameter int CPU_DIV = CPU_DIV_NTSC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic ce_tia,
  output logic ce_cpu
);

  localparam int TW = cnt_w(TIA_DIV);
  localparam int CW = cnt_w(CPU_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(TIA_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CPU_DIV - 1);

  logic [TW-1:0] tia_cnt;
  logic [CW-1:0] cpu_ph;
  logic          tia_wrap;
  logic          cpu_wrap;

  assign tia_wrap = (tia_cnt == T_LAST);
  assign cpu_wrap = (cpu_ph == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tia_cnt <= '0;
      cpu_ph  <= '0;
      ce_tia  <= 1'b0;
      ce_cpu  <= 1'b0;
    end else if (clr) begin
      tia_cnt <= '0;
      cpu_ph  <= '0;
      ce_tia  <= 1'b0;
      ce_cpu  <= 1'b0;
    end else if (run) begin
      ce_tia <= tia_wrap;
      ce_cpu <= tia_wrap & cpu_wrap;
      if (tia_wrap) begin
        tia_cnt <= '0;
        cpu_ph  <= cpu_wrap ? '0 : cpu_ph + 1'b1;
      end else begin
        tia_cnt <= tia_cnt + 1'b1;
      end
    end else begin
      ce_tia <= 1'b0;
      ce_cpu <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock qualification, core reset sequencing and Atari clock enables.
// Optional lock-loss counter port: define PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int TIA_DIV            = TIA_DIV_NTSC,
  parameter int CPU_DIV            = CPU_DIV_NTSC
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       ce_tia,
  output logic       ce_cpu,
`ifdef PLL_LOCK_LOSS_COUNT_EN
  output logic       ready,
  output logic [7:0] lock_lost_cnt
`else
  output logic       ready
`endif
);

  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int HW = cnt_w(RST_HOLD_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(RST_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  pll_state_t             state;
  logic [SW-1:0]          stable_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   div_run;
  logic                   div_clr;
  logic                   lost;

  assign locked_s = sync[SYNC_STAGES-1];
  assign lost     = ~locked_s & ((state == S_HOLD) | (state == S_RUN));

  // Dividers restart from zero on the edge that enters S_HOLD
  assign div_run = locked_s & ((state == S_HOLD) | (state == S_RUN));
  assign div_clr = ~locked_s | (state == S_STABLE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      state      <= S_WAIT_LOCK;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      ready      <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      unique case (state)
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state      <= S_STABLE;
            stable_cnt <= '0;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
          end else if (stable_cnt == S_LAST) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
          end else if (hold_cnt == H_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            ready      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state      <= S_WAIT_LOCK;
            core_reset <= 1'b1;
            ready      <= 1'b0;
          end
        end
        default: begin
          state      <= S_WAIT_LOCK;
          core_reset <= 1'b1;
          ready      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost_cnt <= '0;
    end else if (lost && lock_lost_cnt != 8'hFF) begin
      lock_lost_cnt <= lock_lost_cnt + 1'b1;
    end
  end
`else
  logic unused_lost;
  assign unused_lost = lost;
`endif

  ce_divider #(
    .TIA_DIV (TIA_DIV),
    .CPU_DIV (CPU_DIV)
  ) u_ce_div (
    .clk    (clk_sys),
    .rst_n  (rst_n),
    .run    (div_run),
    .clr    (div_clr),
    .ce_tia (ce_tia),
    .ce_cpu (ce_cpu)
  );

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (SYNC=2, STABLE=16, HOLD=4).
// Edge numbers are relative to the last edge before pll_locked rises.
module tb_pll_lock_sequencer;

  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic core_reset;
  logic ce_tia;
  logic ce_cpu;
  logic ready;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] lock_lost_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  pll_lock_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (16),
    .RST_HOLD_CYCLES    (4),
    .TIA_DIV            (8),
    .CPU_DIV            (3)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .core_reset    (core_reset),
    .ce_tia        (ce_tia),
    .ce_cpu        (ce_cpu),
`ifdef PLL_LOCK_LOSS_COUNT_EN
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt)
`else
    .ready         (ready)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    pll_locked = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Raise lock (or keep it high) and record first-event edges.
  task automatic seq(input int n, output int t_rst, output int t_rdy,
                     output int t_tia, output int t_cpu);
    int e;
    base = cyc;
    pll_locked = 1'b1;
    t_rst = -1;
    t_rdy = -1;
    t_tia = -1;
    t_cpu = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      e = cyc - base;
      if (t_rst < 0 && core_reset == 1'b0) t_rst = e;
      if (t_rdy < 0 && ready == 1'b1) t_rdy = e;
      if (t_tia < 0 && ce_tia == 1'b1) t_tia = e;
      if (t_cpu < 0 && ce_cpu == 1'b1) t_cpu = e;
    end
  endtask

  int tr, ty, tt, tc;
  int e, bad_t, bad_c, orphan, n_t, n_c, ce_seen, tmo;

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_ce_tia", ce_tia, 0);
    chk("rst_ce_cpu", ce_cpu, 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk("rst_lost_cnt", lock_lost_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (4) tick();
    chk("wait_core_reset", core_reset, 1);

    // 1: sample at edge 1, STABLE at 3, HOLD at 19, RUN at 23
    seq(50, tr, ty, tt, tc);
    chk("t1_core_reset_fall", tr, 23);
    chk("t1_ready_rise", ty, 23);
    chk("t1_first_ce_tia", tt, 27);
    chk("t1_first_ce_cpu", tc, 43);

    // 2: 48 cycles in RUN, phases anchored at edges 27 and 43
    bad_t = 0; bad_c = 0; orphan = 0; n_t = 0; n_c = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      e = cyc - base;
      if (ce_tia !== (((e - 27) % 8) == 0)) bad_t++;
      if (ce_cpu !== (((e - 43) % 24) == 0)) bad_c++;
      if (ce_cpu && !ce_tia) orphan++;
      if (ce_tia) n_t++;
      if (ce_cpu) n_c++;
    end
    chk("t2_tia_phase_errs", bad_t, 0);
    chk("t2_cpu_phase_errs", bad_c, 0);
    chk("t2_cpu_orphans", orphan, 0);
    chk("t2_tia_count", n_t, 6);
    chk("t2_cpu_count", n_c, 2);

    // 4: drop lock in RUN; reaction on 3rd edge after the drop
    pll_locked = 1'b0;
    tick();
    tick();
    chk("t4_still_run_rst", core_reset, 0);
    chk("t4_still_run_rdy", ready, 1);
    tick();
    chk("t4_loss_core_reset", core_reset, 1);
    chk("t4_loss_ready", ready, 0);
    ce_seen = (ce_tia | ce_cpu) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ce_tia || ce_cpu) ce_seen++;
    end
    chk("t4_enables_off", ce_seen, 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk("t4_lost_cnt", lock_lost_cnt, 1);
`endif
    seq(50, tr, ty, tt, tc);
    chk("t4_relock_rst_fall", tr, 23);
    chk("t4_relock_ready", ty, 23);

    // 5: async reset mid-HOLD, then again mid-RUN
    do_reset();
    base = cyc;
    pll_locked = 1'b1;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_hold_rst_core", core_reset, 1);
    chk("t5_hold_rst_ready", ready, 0);
    chk("t5_hold_rst_ce", {ce_tia, ce_cpu}, 0);
    tick();
    rst_n = 1'b1;
    seq(30, tr, ty, tt, tc);
    chk("t5_release_rst_fall", tr, 23);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_run_async_core", core_reset, 1);
    chk("t5_run_async_ready", ready, 0);
    tick();

    // 6 (glitch): 3-cycle drop after edge 11 restarts qualification
    do_reset();
    base = cyc;
    pll_locked = 1'b1;
    tr = -1; ty = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      e = cyc - base;
      if (tr < 0 && core_reset == 1'b0) tr = e;
      if (ty < 0 && ready == 1'b1) ty = e;
      if (i == 11) pll_locked = 1'b0;
      if (i == 14) pll_locked = 1'b1;
    end
    chk("t3_glitch_rst_fall", tr, 37);
    chk("t3_glitch_ready", ty, 37);

`ifdef PLL_LOCK_LOSS_COUNT_EN
    // Saturation of the lock-loss counter
    do_reset();
    tmo = 0;
    for (int k = 1; k <= 300; k++) begin
      pll_locked = 1'b1;
      for (int i = 0; i < 40 && !ready; i++) tick();
      if (!ready) tmo++;
      pll_locked = 1'b0;
      repeat (4) tick();
      if (k == 10) chk("t6_lost_cnt_10", lock_lost_cnt, 10);
    end
    chk("t6_ready_timeouts", tmo, 0);
    chk("t6_lost_cnt_sat", lock_lost_cnt, 255);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
